mont_stream_loader: RTL and testbench

Word-serial front end for the 512-bit Montgomery multiplier. It accepts operands A, B and M as a stream of 32-bit words and assembles each into a 512-bit register. It then pulses the multiplier's start input and holds the operands stable until done. It captures the 512-bit result on the done pulse and streams it back out as 32-bit words. The block sits between the bus/DMA side and the multiplier core.

---
 rtl/mont_pkg.sv | 27 ++
 rtl/mont_stream_loader_if.sv | 42 ++++
 rtl/mont_word_shreg.sv | 33 +++
 rtl/mont_stream_loader.sv | 151 +++++++++++++++
 tb/tb_mont_stream_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared constants, loader state encoding and operand selection for the
// word-serial Montgomery front end.
package mont_pkg;

  localparam int WORD_W = 32;
  localparam int OP_W   = 512;
  localparam int WORDS  = OP_W / WORD_W;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } loader_state_t;

  localparam logic [1:0] OPA = 2'd0;
  localparam logic [1:0] OPB = 2'd1;
  localparam logic [1:0] OPM = 2'd2;

  // Frame word index -> operand register it belongs to.
  function automatic logic [1:0] op_index(input logic [5:0] cnt, input int words);
    if (int'(cnt) < words) return OPA;
    if (int'(cnt) < 2 * words) return OPB;
    return OPM;
  endfunction

endpackage

// File: rtl/mont_stream_loader_if.sv
// Stream and multiplier-side signal bundle for mont_stream_loader.
// slave = the loader itself, master = whatever drives the streams and the core.
interface mont_stream_loader_if #(
  parameter int WORD_W = mont_pkg::WORD_W,
  parameter int OP_W   = mont_pkg::OP_W
);

  // Both streams: a word moves on a rising clk where valid & ready are both 1;
  // valid and data stay put until that happens, ready may toggle freely.
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              cfg_keep_m;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  logic              busy;
  logic              mont_start;
  logic [OP_W-1:0]   mont_a;
  logic [OP_W-1:0]   mont_b;
  logic [OP_W-1:0]   mont_m;
  logic [OP_W-1:0]   mont_result;
  logic              mont_done;

  mont_pkg::loader_state_t dbg_state;

  modport slave (
    input  in_valid, in_data, cfg_keep_m, out_ready, mont_result, mont_done,
    output in_ready, out_valid, out_data, out_last, busy, mont_start,
           mont_a, mont_b, mont_m, dbg_state
  );

  modport master (
    output in_valid, in_data, cfg_keep_m, out_ready, mont_result, mont_done,
    input  in_ready, out_valid, out_data, out_last, busy, mont_start,
           mont_a, mont_b, mont_m, dbg_state
  );

endinterface

// File: rtl/mont_word_shreg.sv
// OP_W-wide register: parallel load, shift a word in at the top, or shift the
// bottom word out (zero fill). Priority: load, shift-in, shift-out.
module mont_word_shreg #(
  parameter int OP_W   = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [OP_W-1:0]   load_data_i,
  input  logic              shift_in_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              shift_out_i,
  output logic [OP_W-1:0]   data_o
);

  logic [OP_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_in_i) begin
      data_q <= {word_i, data_q[OP_W-1:WORD_W]};
    end else if (shift_out_i) begin
      data_q <= {{WORD_W{1'b0}}, data_q[OP_W-1:WORD_W]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mont_stream_loader.sv
// Word-serial front end for the 512-bit Montgomery multiplier: loads A/B/M,
// pulses start, captures the result and streams it out. MONT_LOADER_KEEPM_EN
// enables reuse of the stored M via cfg_keep_m (32-word frames).
module mont_stream_loader #(
  parameter int WORD_W = mont_pkg::WORD_W,
  parameter int OP_W   = mont_pkg::OP_W
) (
  input logic                 clk,
  input logic                 reset,
  mont_stream_loader_if.slave lif
);

  import mont_pkg::*;

  localparam int         N_WORDS  = OP_W / WORD_W;
  localparam logic [5:0] LAST_AB  = 6'(2 * N_WORDS - 1);
  localparam logic [5:0] LAST_ABM = 6'(3 * N_WORDS - 1);
  localparam logic [5:0] LAST_OUT = 6'(N_WORDS - 1);

  loader_state_t state_q;
  logic [5:0]    cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;
  logic          start_q;

  logic            keep_active;
  logic            in_fire;
  logic            out_fire;
  logic            capture;
  logic            frame_end;
  logic [1:0]      op_sel;
  logic [OP_W-1:0] a_data, b_data, m_data, res_data;
  logic            res_unused;

  assign in_fire   = lif.in_valid & in_ready_q;
  assign out_fire  = out_valid_q & lif.out_ready;
  assign capture   = (state_q == ST_WAIT) & lif.mont_done;
  assign op_sel    = op_index(cnt_q, N_WORDS);
  assign frame_end = (cnt_q == LAST_ABM) | (keep_active & (cnt_q == LAST_AB));

`ifdef MONT_LOADER_KEEPM_EN
  // The keep request applies to the whole frame, so only the first word counts.
  logic keep_m_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keep_m_q <= 1'b0;
    end else if (in_fire && (cnt_q == 6'd0)) begin
      keep_m_q <= lif.cfg_keep_m;
    end
  end
  assign keep_active = keep_m_q;
`else
  logic keep_unused;
  assign keep_unused = lif.cfg_keep_m;
  assign keep_active = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (in_fire) begin
            if (frame_end) begin
              cnt_q      <= '0;
              state_q    <= ST_START;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              start_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (lif.mont_done) begin
            state_q     <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST_OUT == 6'd0);
          end
        end
        ST_DRAIN: begin
          if (lif.out_ready) begin
            if (cnt_q == LAST_OUT) begin
              state_q     <= ST_LOAD;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 6'd1;
              out_last_q <= ((cnt_q + 6'd1) == LAST_OUT);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Operand registers only move on accepted input words, i.e. only in LOAD.
  mont_word_shreg #(.OP_W(OP_W), .WORD_W(WORD_W)) u_a (
    .clk(clk), .reset(reset), .load_i(1'b0), .load_data_i('0),
    .shift_in_i(in_fire & (op_sel == OPA)), .word_i(lif.in_data),
    .shift_out_i(1'b0), .data_o(a_data)
  );

  mont_word_shreg #(.OP_W(OP_W), .WORD_W(WORD_W)) u_b (
    .clk(clk), .reset(reset), .load_i(1'b0), .load_data_i('0),
    .shift_in_i(in_fire & (op_sel == OPB)), .word_i(lif.in_data),
    .shift_out_i(1'b0), .data_o(b_data)
  );

  mont_word_shreg #(.OP_W(OP_W), .WORD_W(WORD_W)) u_m (
    .clk(clk), .reset(reset), .load_i(1'b0), .load_data_i('0),
    .shift_in_i(in_fire & (op_sel == OPM)), .word_i(lif.in_data),
    .shift_out_i(1'b0), .data_o(m_data)
  );

  mont_word_shreg #(.OP_W(OP_W), .WORD_W(WORD_W)) u_res (
    .clk(clk), .reset(reset), .load_i(capture), .load_data_i(lif.mont_result),
    .shift_in_i(1'b0), .word_i('0),
    .shift_out_i(out_fire), .data_o(res_data)
  );

  assign res_unused = ^res_data[OP_W-1:WORD_W];

  assign lif.in_ready   = in_ready_q;
  assign lif.out_valid  = out_valid_q;
  assign lif.out_data   = res_data[WORD_W-1:0];
  assign lif.out_last   = out_last_q;
  assign lif.busy       = busy_q;
  assign lif.mont_start = start_q;
  assign lif.mont_a     = a_data;
  assign lif.mont_b     = b_data;
  assign lif.mont_m     = m_data;
  assign lif.dbg_state  = state_q;

endmodule

// File: tb/tb_mont_stream_loader.sv
// Randomized bench for mont_stream_loader: operand frames, a multiplier stub
// and a result-stream scoreboard built from a word-level model.
module tb_mont_stream_loader;

  localparam int W   = 32;
  localparam int OPW = 512;
  localparam int NW  = OPW / W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_stream_loader_if #(.WORD_W(W), .OP_W(OPW)) lif ();
  mont_stream_loader #(.WORD_W(W), .OP_W(OPW)) dut (.clk(clk), .reset(rst), .lif(lif));

  int errors  = 0;
  int checks  = 0;
  int n_start = 0;
  bit stall_en = 1'b0;
  logic [W:0]     exp_q[$];
  logic [OPW-1:0] mdl_a, mdl_b, mdl_m;
  logic [W-1:0]   fw[3*NW];

  task automatic chk(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, lif.in_ready, 1);
    chk({tag, "_out_valid"}, lif.out_valid, 0);
    chk({tag, "_out_last"}, lif.out_last, 0);
    chk({tag, "_out_data"}, lif.out_data, 0);
    chk({tag, "_busy"}, lif.busy, 0);
    chk({tag, "_mont_start"}, lif.mont_start, 0);
    chk({tag, "_mont_a"}, lif.mont_a, 0);
    chk({tag, "_mont_b"}, lif.mont_b, 0);
    chk({tag, "_mont_m"}, lif.mont_m, 0);
  endtask

  // Multiplier stub: done 10 cycles after start, result = a ^ b ^ m.
  initial begin
    logic [OPW-1:0] r;
    bit aborted;
    lif.mont_done   = 1'b0;
    lif.mont_result = '0;
    forever begin
      @(negedge clk);
      if (!rst && lif.mont_start === 1'b1) begin
        n_start++;
        chk("op_a", lif.mont_a, mdl_a);
        chk("op_b", lif.mont_b, mdl_b);
        chk("op_m", lif.mont_m, mdl_m);
        aborted = 1'b0;
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          lif.mont_result = lif.mont_a ^ lif.mont_b ^ lif.mont_m;
          lif.mont_done   = 1'b1;
          r = mdl_a ^ mdl_b ^ mdl_m;
          for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), r[W*i +: W]});
          @(negedge clk);
          lif.mont_done = 1'b0;
        end
      end
    end
  end

  // Output side: random ready, compare every valid cycle, check stall hold.
  initial begin
    logic [W:0] prev;
    bit prev_stall;
    prev_stall    = 1'b0;
    prev          = '0;
    lif.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      lif.out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst) begin
        prev_stall = 1'b0;
      end else if (lif.out_valid === 1'b1) begin
        if (prev_stall) chk("stall_hold", {lif.out_last, lif.out_data}, prev);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {lif.out_last, lif.out_data}, '1);
        end else begin
          chk("out_word", {lif.out_last, lif.out_data}, exp_q[0]);
        end
        if (lif.out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev = {lif.out_last, lif.out_data};
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic keep, input int gap);
    int t;
    lif.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    lif.in_valid   = 1'b1;
    lif.in_data    = d;
    lif.cfg_keep_m = keep;
    t = 0;
    while (lif.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", lif.in_ready, 1);
    @(negedge clk);
    lif.in_valid = 1'b0;
  endtask

  task automatic inject_done();
    logic [OPW-1:0] r;
    for (int i = 0; i < NW; i++) r[W*i +: W] = $urandom();
    lif.mont_result = r;
    lif.mont_done   = 1'b1;
    @(negedge clk);
    lif.mont_done   = 1'b0;
    lif.mont_result = '0;
  endtask

  task automatic run_frame(input bit keep, input int gap_max, input int inject_at);
    int n;
    n = 3 * NW;
`ifdef MONT_LOADER_KEEPM_EN
    if (keep) n = 2 * NW;
`endif
    for (int k = 0; k < NW; k++) begin
      mdl_a[W*k +: W] = fw[k];
      mdl_b[W*k +: W] = fw[NW + k];
      if (n == 3 * NW) mdl_m[W*k +: W] = fw[2*NW + k];
    end
    for (int k = 0; k < n; k++) begin
      if (k == inject_at) begin
        inject_done();
        chk("load_done_in_ready", lif.in_ready, 1);
        chk("load_done_busy", lif.busy, 0);
        chk("load_done_out_valid", lif.out_valid, 0);
        chk("load_done_out_data", lif.out_data, 0);
      end
      send_word(fw[k], (k == 0) ? keep : 1'($urandom_range(0, 1)), $urandom_range(0, gap_max));
      if (k == 2*NW - 1) begin
        chk("frame_len_start", lif.mont_start, (n == 2 * NW));
        chk("frame_len_ready", lif.in_ready, (n == 3 * NW));
      end
    end
    chk("start_pulse", lif.mont_start, 1);
    chk("start_ready_busy", {lif.in_ready, lif.busy}, 2'b01);
    @(negedge clk);
    chk("start_once", lif.mont_start, 0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((lif.busy === 1'b1 || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", {lif.busy, 1'(exp_q.size() != 0)}, 2'b00);
  endtask

  task automatic random_words();
    for (int k = 0; k < 3*NW; k++) fw[k] = $urandom();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [OPW-1:0] r;
    logic [OPW-1:0] m_prev;
    int t;
    lif.in_valid   = 1'b0;
    lif.in_data    = '0;
    lif.cfg_keep_m = 1'b0;
    mdl_a = '0;
    mdl_b = '0;
    mdl_m = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: word k = k+1, no gaps, no stalls.
    for (int k = 0; k < 3*NW; k++) fw[k] = W'(k + 1);
    run_frame(1'b0, 0, -1);
    chk("lit_a_w0", lif.mont_a[31:0], 32'd1);
    chk("lit_b_w0", lif.mont_b[31:0], 32'd17);
    chk("lit_m_top", lif.mont_m[511:480], 32'd48);
    r = mdl_a ^ mdl_b ^ mdl_m;
    chk("lit_res_w0", r[31:0], 32'd49);
    wait_drain();

    // Frame 2: gaps, stalls, done injected during LOAD and during DRAIN.
    stall_en = 1'b1;
    random_words();
    run_frame(1'b0, 2, 5);
    t = 0;
    while (lif.out_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    inject_done();
    chk("drain_done_busy", lif.busy, 1);
    chk("drain_done_valid", lif.out_valid, 1);
    wait_drain();

    // Frame 3: keep_m requested on the first word.
    m_prev = mdl_m;
    random_words();
    run_frame(1'b1, 2, -1);
`ifdef MONT_LOADER_KEEPM_EN
    chk("keep_m_held", lif.mont_m, m_prev);
`endif
    wait_drain();

    // Frame 4: reset asserted while the multiplier is running.
    random_words();
    run_frame(1'b0, 1, -1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_a = '0;
    mdl_b = '0;
    mdl_m = '0;
    chk("midrst_no_result", exp_q.size(), 0);
    @(negedge clk);

    // Frame 5: all ones.
    for (int k = 0; k < 3*NW; k++) fw[k] = 32'hFFFF_FFFF;
    run_frame(1'b0, 1, -1);
    r = mdl_a ^ mdl_b ^ mdl_m;
    chk("lit_ff_w0", r[31:0], 32'hFFFF_FFFF);
    wait_drain();

    for (int f = 0; f < 3; f++) begin
      stall_en = ($urandom_range(0, 1) == 1);
      random_words();
      run_frame(1'($urandom_range(0, 1)), 3, -1);
      wait_drain();
    end

    chk("start_count", n_start, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
